// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive path: FSM states, FIFO entry layout and counter-width helper.
// Pure declarations; no timing or backpressure of its own.
package uart_rx_pkg;

  localparam int MAX_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  typedef struct packed {
    logic                      frame_err;
    logic                      parity_err;
    logic [MAX_DATA_WIDTH-1:0] data;
  } rx_entry_s;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO of received frames; head valid the cycle after the push edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push_vld,
  input  rx_entry_s              i_push_dat,
  input  logic                   i_pop_rdy,
  output logic                   o_head_vld,
  output rx_entry_s              o_head_dat,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rx_entry_s        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign o_head_vld = (r_count != '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign w_pop      = i_pop_rdy & o_head_vld;
  assign w_push     = i_push_vld & (~o_full | w_pop);
  // Stale memory is never visible: the head is forced to zero while empty.
  assign o_head_dat = o_head_vld ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver into a FWFT FIFO; frame pushed at mid last stop bit, head visible next cycle.
// Backpressure: frames arriving with a full FIFO are dropped and flagged by sticky overrun.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_parity_err,
  output logic                        m_frame_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        clr_overrun,
  output logic                        break_det
);

  localparam int DIV_W  = cnt_w(CLK_DIV);
  localparam int SCNT_W = cnt_w(OVERSAMPLE);
  localparam int IDX_W  = cnt_w(DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SCNT_W-1:0] MID_START = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] MID_BIT   = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic              ODD       = 1'(PARITY_ODD);

  rx_state_e           r_state, w_next;
  logic                r_sync1, r_sync2;
  logic [DIV_W-1:0]    r_div;
  logic [SCNT_W-1:0]   r_s_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic                r_par_err, r_par_bit, r_frame_err, r_stop_idx;
  logic                w_rx_s, w_tick, w_mid, w_stop_last;
  logic                w_push, w_fe_now, w_break, w_full, w_drop;
  rx_entry_s           w_push_dat, w_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {r_sync2, r_sync1} <= 2'b11;
    else      {r_sync2, r_sync1} <= {r_sync1, rx};
  end
  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end
  assign w_tick = (r_div == DIV_LAST);

  // START samples half a bit in; later states sample a full bit later, i.e. mid-bit.
  assign w_mid       = w_tick && (r_s_cnt == ((r_state == ST_START) ? MID_START : MID_BIT));
  assign w_stop_last = (STOP_BITS == 1) || r_stop_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (!w_rx_s) w_next = ST_START;
      ST_START:     if (w_mid) w_next = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_mid && r_idx == IDX_LAST) w_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (w_mid) w_next = ST_STOP;
      ST_STOP:      if (w_mid && w_stop_last) w_next = w_fe_now ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: if (w_rx_s) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_push   = 1'b0;
    w_fe_now = r_frame_err | ~w_rx_s;
    w_break  = 1'b0;
    if (r_state == ST_STOP && w_mid && w_stop_last) begin
      w_push  = 1'b1;
      w_break = w_fe_now && (r_data == '0) && !r_par_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_cnt     <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_par_err   <= 1'b0;
      r_par_bit   <= 1'b0;
      r_frame_err <= 1'b0;
      r_stop_idx  <= 1'b0;
    end else if (r_state == ST_IDLE || r_state == ST_WAIT_IDLE) begin
      r_s_cnt <= '0;
    end else if (w_tick) begin
      r_s_cnt <= w_mid ? '0 : r_s_cnt + 1'b1;
      if (w_mid) begin
        case (r_state)
          ST_START: begin
            r_idx       <= '0;
            r_data      <= '0;
            r_par_err   <= 1'b0;
            r_par_bit   <= 1'b0;
            r_frame_err <= 1'b0;
            r_stop_idx  <= 1'b0;
          end
          ST_DATA: begin
            r_data[r_idx] <= w_rx_s;
            r_idx         <= r_idx + 1'b1;
          end
          ST_PARITY: begin
            r_par_bit <= w_rx_s;
            r_par_err <= ((^r_data) ^ w_rx_s) != ODD;
          end
          ST_STOP: begin
            if (!w_rx_s) r_frame_err <= 1'b1;
            r_stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_push_dat.frame_err  = w_fe_now;
  assign w_push_dat.parity_err = r_par_err;
  assign w_push_dat.data       = MAX_DATA_WIDTH'(r_data);

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (w_push),
    .i_push_dat (w_push_dat),
    .i_pop_rdy  (m_ready),
    .o_head_vld (m_valid),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_count    (fifo_count)
  );

  assign w_drop = w_push & w_full & ~(m_valid & m_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             overrun <= 1'b0;
    else if (w_drop)      overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  assign m_data       = w_head.data[DATA_WIDTH-1:0];
  assign m_parity_err = w_head.parity_err;
  assign m_frame_err  = w_head.frame_err;
  assign break_det    = w_break;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: default 8N1 instance plus an 8E1 instance for parity cases.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst, rx, rx_p, m_ready, m_ready_p, clr_overrun;
  logic       m_valid, m_parity_err, m_frame_err, overrun, break_det;
  logic [7:0] m_data;
  logic [3:0] fifo_count;
  logic       p_valid, p_parity_err, p_frame_err, p_overrun, p_break;
  logic [7:0] p_data;
  logic [3:0] p_count;
  int         checks = 0;
  int         errors = 0;
  int         brk_cnt = 0;
  int         brk0;

  always #5 clk = ~clk;

  uart_rx_ctrl u_dut (
    .clk(clk), .rst(rst), .rx(rx), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
    .fifo_count(fifo_count), .overrun(overrun), .clr_overrun(clr_overrun),
    .break_det(break_det)
  );

  uart_rx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
    .clk(clk), .rst(rst), .rx(rx_p), .m_valid(p_valid), .m_ready(m_ready_p),
    .m_data(p_data), .m_parity_err(p_parity_err), .m_frame_err(p_frame_err),
    .fifo_count(p_count), .overrun(p_overrun), .clr_overrun(clr_overrun),
    .break_det(p_break)
  );

  always @(negedge clk) if (break_det === 1'b1) brk_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * 64) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par, input logic par);
    drive(sel, 1'b0);
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_bits(1);
    end
    if (has_par) begin
      drive(sel, par);
      wait_bits(1);
    end
    drive(sel, 1'b1);
    wait_bits(1);
  endtask

  task automatic pop(input bit sel);
    if (sel) m_ready_p = 1'b1; else m_ready = 1'b1;
    @(negedge clk);
    m_ready_p = 1'b0;
    m_ready   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1;
    m_ready = 1'b0; m_ready_p = 1'b0; clr_overrun = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",   m_valid, 0);
    check("rst_count",   fifo_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_break",   break_det, 0);
    check("rst_data",    m_data, 0);
    rst = 1'b1;
    wait_bits(1);

    // 0xA5: push lands near 9.5 bit times after the start edge
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
      begin
        wait_bits(9);
        check("a5_not_early", m_valid, 0);
        wait_bits(1);
        check("a5_valid", m_valid, 1);
      end
    join
    check("a5_data",  m_data, 8'hA5);
    check("a5_perr",  m_parity_err, 0);
    check("a5_ferr",  m_frame_err, 0);
    check("a5_count", fifo_count, 1);
    pop(1'b0);
    check("a5_popped", fifo_count, 0);

    // 20-clk glitch must be rejected, and the receiver must still work afterwards
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    wait_bits(2);
    check("glitch_valid", m_valid, 0);
    check("glitch_count", fifo_count, 0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
    check("post_glitch_data",  m_data, 8'h5A);
    check("post_glitch_count", fifo_count, 1);
    pop(1'b0);

    // Even parity on 0x07 (three ones) needs parity bit 1
    send_frame(1'b1, 8'h07, 1'b1, 1'b0);
    check("par0_valid", p_valid, 1);
    check("par0_data",  p_data, 8'h07);
    check("par0_perr",  p_parity_err, 1);
    pop(1'b1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1);
    check("par1_data",  p_data, 8'h07);
    check("par1_perr",  p_parity_err, 0);
    check("par1_ferr",  p_frame_err, 0);
    pop(1'b1);

    // Nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0);
    check("ovr_count", fifo_count, 8);
    check("ovr_flag",  overrun, 1);
    check("ovr_head",  m_data, 8'h01);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), m_data, i);
      pop(1'b0);
    end
    check("drain_count", fifo_count, 0);
    check("drain_valid", m_valid, 0);

    // Break: line low for 15 bit times
    brk0 = brk_cnt;
    rx = 1'b0;
    wait_bits(15);
    check("brk_count", fifo_count, 1);
    check("brk_data",  m_data, 0);
    check("brk_ferr",  m_frame_err, 1);
    check("brk_pulses", brk_cnt - brk0, 1);
    rx = 1'b1;
    wait_bits(2);
    check("brk_no_extra", fifo_count, 1);
    pop(1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    check("post_brk_count", fifo_count, 1);
    check("post_brk_data",  m_data, 8'h3C);
    check("post_brk_ferr",  m_frame_err, 0);
    pop(1'b0);

    // Reset in the middle of 0x55 with one entry already queued
    send_frame(1'b0, 8'h11, 1'b0, 1'b0);
    check("pre_rst_count", fifo_count, 1);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 3; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;
      wait_bits(1);
    end
    rst = 1'b0;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_data",  m_data, 0);
    check("midrst_ferr",  m_frame_err, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    wait_bits(2);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0);
    check("c3_count", fifo_count, 1);
    check("c3_data",  m_data, 8'hC3);
    check("c3_perr",  m_parity_err, 0);
    check("c3_ferr",  m_frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
